// File: rtl/intr_defs.sv
// intr_defs -- constants shared by the interrupt controller and the CPU
// sequencer: FSM state encodings, default vector table placement and a few
// small helpers used to size and address the vector table.
package intr_defs;

  // Default geometry of the interrupt vector table
  localparam int unsigned N_INTR_DEF     = 8;
  localparam int unsigned ADDR_W_DEF     = 10;
  localparam int unsigned VEC_BASE_DEF   = 32'h35C;
  localparam int unsigned VEC_STRIDE_DEF = 20;

  // Controller state; the CPU sequencer decodes the same encoding
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } intr_state_e;

  // Width of a line index for n interrupt lines (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Full-width vector address of line idx; callers truncate to ADDR_W
  function automatic logic [31:0] vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return 32'(base + idx * stride);
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc -- combinational priority select and vector computation.
// Picks the lowest-index set bit of the eligible vector (bit 0 wins) and
// produces its vector address VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W.
//
// Ports
//   eligible  in   N_INTR  pending & ~mask
//   sel_any   out  1       at least one eligible line
//   sel_idx   out  IDX_W   index of the selected line (0 when none)
//   sel_vec   out  ADDR_W  vector address of sel_idx
module intr_prio_enc
  import intr_defs::*;
#(
  parameter int unsigned N_INTR     = N_INTR_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int unsigned IDX_W      = idx_width(N_INTR)
) (
  input  logic [N_INTR-1:0] eligible,
  output logic              sel_any,
  output logic [IDX_W-1:0]  sel_idx,
  output logic [ADDR_W-1:0] sel_vec
);

  logic [31:0] vec_full;

  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = '0;
    // Scan from the top down so the last hit, the lowest index, wins
    for (int i = N_INTR - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    vec_full = vec_addr(VEC_BASE, VEC_STRIDE, 32'(sel_idx));
    sel_vec  = vec_full[ADDR_W-1:0];
  end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl -- prioritised interrupt controller with edge-detected requests,
// a mask register, a pending register and a two-state IDLE/SERVICE FSM.
//
// Ports
//   clk           in   1       sole clock, rising edge
//   reset         in   1       synchronous, active-high reset
//   intr_req      in   N_INTR  raw request lines, bit 0 highest priority
//   intr_en       in   1       global enable for presenting to the CPU
//   mask_we       in   1       mask register write strobe
//   mask_in       in   N_INTR  new mask value, 1 = masked
//   intr_ack      in   1       CPU accepts the presented interrupt
//   intr_ret      in   1       CPU return-from-interrupt
//   intr_out      out  1       registered interrupt request to the CPU
//   intr_dir_out  out  ADDR_W  registered vector address (0 when intr_out=0)
//   intr_pending  out  N_INTR  pending register
//   intr_busy     out  1       high while in SERVICE
module intr_ctrl
  import intr_defs::*;
#(
  parameter int unsigned N_INTR     = N_INTR_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr_req,
  input  logic              intr_en,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_in,
  input  logic              intr_ack,
  input  logic              intr_ret,
  output logic              intr_out,
  output logic [ADDR_W-1:0] intr_dir_out,
  output logic [N_INTR-1:0] intr_pending,
  output logic              intr_busy
);

  localparam int unsigned IDX_W = idx_width(N_INTR);

  // Elaboration guards: legal line count and a vector table that does not
  // wrap onto itself inside ADDR_W bits
  if (N_INTR < 2 || N_INTR > 32) begin : g_bad_n_intr
    $error("intr_ctrl: N_INTR must be within 2..32");
  end
  if (VEC_STRIDE == 0) begin : g_bad_stride
    $error("intr_ctrl: VEC_STRIDE must be non-zero");
  end
  if (ADDR_W < 32) begin : g_chk_span
    if ((64'(N_INTR - 1) * 64'(VEC_STRIDE)) >= (64'd1 << ADDR_W)) begin : g_bad_span
      $error("intr_ctrl: vector table wraps within ADDR_W bits");
    end
  end

  logic [N_INTR-1:0] req_p0;     // previous sample of intr_req
  logic              armed;      // req_p0 holds a real post-reset sample
  logic [N_INTR-1:0] pending;
  logic [N_INTR-1:0] mask;
  logic [N_INTR-1:0] rise;
  logic [N_INTR-1:0] eligible;
  logic [N_INTR-1:0] ack_clr;
  logic [IDX_W-1:0]  pres_idx;   // line currently shown on intr_dir_out
  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] sel_vec;
  logic              take_ack;
  logic              present_n;
  intr_state_e       state;
  intr_state_e       state_n;

  // Edge detection is suppressed for the first cycle after reset so that a
  // line already high at release has to drop and rise again to be seen
  assign rise     = armed ? (intr_req & ~req_p0) : '0;
  assign eligible = pending & ~mask;

  // An ack only counts against a vector actually on the outputs, so a line
  // withdrawn by intr_en or the mask can never be acknowledged stale
  assign take_ack = intr_ack & intr_out;

  intr_prio_enc #(
    .N_INTR    (N_INTR),
    .ADDR_W    (ADDR_W),
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE),
    .IDX_W     (IDX_W)
  ) u_prio_enc (
    .eligible(eligible),
    .sel_any (sel_any),
    .sel_idx (sel_idx),
    .sel_vec (sel_vec)
  );

  always_comb begin
    ack_clr = '0;
    if (take_ack) begin
      ack_clr[pres_idx] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (take_ack) state_n = ST_SERVICE;
      ST_SERVICE: if (intr_ret) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Present only while staying in IDLE; the ack edge and the cycle that
  // leaves SERVICE both leave intr_out low
  assign present_n = (state == ST_IDLE) && !take_ack && intr_en && sel_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_p0       <= '0;
      armed        <= 1'b0;
      pending      <= '0;
      mask         <= '0;
      pres_idx     <= '0;
      intr_out     <= 1'b0;
      intr_dir_out <= '0;
    end else begin
      state   <= state_n;
      req_p0  <= intr_req;
      armed   <= 1'b1;
      // A new edge on the acknowledged line wins over its clear
      pending <= (pending & ~ack_clr) | rise;
      if (mask_we) begin
        mask <= mask_in;
      end
      intr_out     <= present_n;
      intr_dir_out <= present_n ? sel_vec : '0;
      if (present_n) begin
        pres_idx <= sel_idx;
      end
    end
  end

  assign intr_pending = pending;
  assign intr_busy    = (state == ST_SERVICE);

endmodule
